// File: rtl/fp_add_arbiter_pkg.sv
// Shared BN254 Fp-width types and helpers for the Fp arithmetic datapath.
package fp_add_arbiter_pkg;

   localparam int unsigned FP_W = 254;

   typedef logic [FP_W-1:0] uint_fp_t;

   // Response payload for shared-unit arbiters with up to 4 requesters.
   localparam int unsigned RSP_ID_W = 2;

   typedef struct packed {
      logic                valid;
      logic [RSP_ID_W-1:0] id;
      uint_fp_t            data;
   } fp_rsp_t;

   // Raw Fp-width addition; the carry-out is dropped, reduction happens downstream.
   function automatic uint_fp_t fp_raw_add(uint_fp_t a, uint_fp_t b);
      return a + b;
   endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester/response bundle between the Fp sequencers and the shared adder arbiter.
interface fp_add_arbiter_if
   import fp_add_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4
);
   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req_valid;
   uint_fp_t         req_x [N_REQ];
   uint_fp_t         req_y [N_REQ];
   logic [N_REQ-1:0] req_ready;
   logic             rsp_valid;
   logic [ID_W-1:0]  rsp_id;
   uint_fp_t         rsp_data;
   logic [1:0]       in_flight;

   modport master (
      output req_valid, req_x, req_y,
      input  req_ready, rsp_valid, rsp_id, rsp_data, in_flight
   );

   modport slave (
      input  req_valid, req_x, req_y,
      output req_ready, rsp_valid, rsp_id, rsp_data, in_flight
   );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after i_ptr, wrapping to 0.
module fp_add_arbiter_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   int unsigned w_j;

   // Rotating priority search producing a one-hot grant and its index.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = 32'(i_ptr) + k;
         if (w_j >= N) begin
            w_j = w_j - N;
         end
         if (!o_any && i_req[IDX_W'(w_j)]) begin
            o_any                  = 1'b1;
            o_grant[IDX_W'(w_j)]   = 1'b1;
            o_idx                  = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/multi_cycle_adder.sv
// Fp-width raw adder with a selectable pipeline depth of 0, 1 or 2 cycles.
module multi_cycle_adder
   import fp_add_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic     clk,
   input  uint_fp_t x,
   input  uint_fp_t y,
   output uint_fp_t z
);

   if (LATENCY == 0) begin : g_comb
      logic w_unused_clk;
      assign w_unused_clk = clk;
      assign z = fp_raw_add(x, y);
   end else if (LATENCY == 1) begin : g_lat1
      uint_fp_t r_z;
      // Single-stage sum register; datapath is never reset.
      always_ff @(posedge clk) begin
         r_z <= fp_raw_add(x, y);
      end
      assign z = r_z;
   end else begin : g_lat2
      uint_fp_t r_s;
      uint_fp_t r_z;
      // Sum then retime; datapath is never reset.
      always_ff @(posedge clk) begin
         r_s <= fp_raw_add(x, y);
         r_z <= r_s;
      end
      assign z = r_z;
   end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one multi_cycle_adder among N_REQ requesters with round-robin issue
// and a tag pipeline that returns each sum with its requester id.
module fp_add_arbiter
   import fp_add_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned LATENCY = 2
) (
   input  logic               clk,
   input  logic               rstn,
   fp_add_arbiter_if.slave    bus
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_idx;
   logic             w_any;
   logic             w_accept;
   logic [ID_W-1:0]  r_rr_ptr;
   uint_fp_t         w_x;
   uint_fp_t         w_y;
   uint_fp_t         w_z;

   fp_add_arbiter_rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_rr (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign bus.req_ready = w_grant;
   assign w_accept      = w_any;

   // Operand mux from the winning requester.
   assign w_x = bus.req_x[w_idx];
   assign w_y = bus.req_y[w_idx];

   // Advance the priority pointer past the requester just served.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_rr_ptr <= (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + ID_W'(1);
      end
   end

   multi_cycle_adder #(
      .LATENCY (LATENCY)
   ) u_add (
      .clk (clk),
      .x   (w_x),
      .y   (w_y),
      .z   (w_z)
   );

   assign bus.rsp_data = w_z;

   if (LATENCY == 0) begin : g_lat0
      assign bus.rsp_valid = w_accept;
      assign bus.rsp_id    = w_idx;
      assign bus.in_flight = '0;
   end else begin : g_tags
      logic [LATENCY-1:0] r_tag_v;
      logic [ID_W-1:0]    r_tag_id [LATENCY];
      logic [1:0]         w_cnt;

      // Tag shift register kept in lockstep with the adder pipeline.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_tag_v <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
               r_tag_id[i] <= '0;
            end
         end else begin
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_idx;
            for (int i = 1; i < int'(LATENCY); i++) begin
               r_tag_v[i]  <= r_tag_v[i-1];
               r_tag_id[i] <= r_tag_id[i-1];
            end
         end
      end

      // Number of tagged operations still inside the adder.
      always_comb begin
         w_cnt = '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            w_cnt = w_cnt + 2'(r_tag_v[i]);
         end
      end

      assign bus.rsp_valid = r_tag_v[LATENCY-1];
      assign bus.rsp_id    = r_tag_id[LATENCY-1];
      assign bus.in_flight = w_cnt;
   end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: drives LATENCY 0/1/2 builds with identical traffic
// and compares them with a cycle-indexed request/response model.
module tb_fp_add_arbiter;
   import fp_add_arbiter_pkg::*;

   localparam int unsigned N = 4;
   localparam int M_IDLE = 0;
   localparam int M_RAND = 1;
   localparam int M_ALL  = 2;
   localparam int M_ONE  = 3;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   fp_add_arbiter_if #(.N_REQ(N)) bus0 ();
   fp_add_arbiter_if #(.N_REQ(N)) bus1 ();
   fp_add_arbiter_if #(.N_REQ(N)) bus2 ();

   fp_add_arbiter #(.N_REQ(N), .LATENCY(0)) u_dut_l0 (.clk(clk), .rstn(rstn), .bus(bus0));
   fp_add_arbiter #(.N_REQ(N), .LATENCY(1)) u_dut_l1 (.clk(clk), .rstn(rstn), .bus(bus1));
   fp_add_arbiter #(.N_REQ(N), .LATENCY(2)) u_dut_l2 (.clk(clk), .rstn(rstn), .bus(bus2));

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Requester model and per-cycle history of what was accepted.
   logic [N-1:0] pend;
   uint_fp_t     mx [N];
   uint_fp_t     my [N];
   int           ptr;
   int           cyc;
   int           mode;
   fp_rsp_t      hist [4];
   logic [N-1:0] exp_rdy;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic uint_fp_t rand_fp();
      uint_fp_t v;
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[FP_W-33:0], 32'($urandom())};
      return v;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < 4; i++) hist[i] = '0;
   endtask

   task automatic drive();
      bus0.req_valid = pend;
      bus1.req_valid = pend;
      bus2.req_valid = pend;
      for (int i = 0; i < int'(N); i++) begin
         bus0.req_x[i] = mx[i]; bus0.req_y[i] = my[i];
         bus1.req_x[i] = mx[i]; bus1.req_y[i] = my[i];
         bus2.req_x[i] = mx[i]; bus2.req_y[i] = my[i];
      end
   endtask

   task automatic gen_new();
      for (int i = 0; i < int'(N); i++) begin
         if (!pend[i]) begin
            case (mode)
               M_RAND: begin
                  if ($urandom_range(0, 1) == 1) begin
                     pend[i] = 1'b1;
                     if ($urandom_range(0, 7) == 0) begin
                        mx[i] = '1;
                        my[i] = FP_W'($urandom_range(1, 5));
                     end else begin
                        mx[i] = rand_fp();
                        my[i] = rand_fp();
                     end
                  end
               end
               M_ALL: begin
                  pend[i] = 1'b1;
                  mx[i]   = FP_W'(i);
                  my[i]   = FP_W'(100);
               end
               M_ONE: begin
                  if (i == 3) begin
                     pend[i] = 1'b1;
                     mx[i]   = rand_fp();
                     my[i]   = rand_fp();
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic check_dut(input int lat, input string pfx, input logic [N-1:0] rdy,
                            input logic rv, input logic [1:0] rid, input uint_fp_t rd,
                            input logic [1:0] inf);
      fp_rsp_t e;
      int      infl;
      e    = hist[(cyc - lat) % 4];
      infl = 0;
      for (int d = 1; d <= lat; d++) infl += int'(hist[(cyc - d) % 4].valid);
      check({pfx, "_ready"}, 256'(rdy), 256'(exp_rdy));
      check({pfx, "_rsp_valid"}, 256'(rv), 256'(e.valid));
      if (e.valid) begin
         check({pfx, "_rsp_id"}, 256'(rid), 256'(e.id));
         check({pfx, "_rsp_data"}, 256'(rd), 256'(e.data));
      end
      check({pfx, "_in_flight"}, 256'(inf), 256'(infl));
   endtask

   // One clock: model arbitration, sample at negedge, update at posedge, drive new inputs.
   task automatic step();
      int      w;
      fp_rsp_t cur;
      w = -1;
      for (int k = 0; k < int'(N); k++) begin
         int j;
         j = (ptr + k) % int'(N);
         if (w < 0 && pend[j]) w = j;
      end
      cur = '0;
      if (w >= 0) begin
         cur.valid = 1'b1;
         cur.id    = RSP_ID_W'(w);
         cur.data  = mx[w] + my[w];
      end
      hist[cyc % 4] = cur;
      exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
      @(negedge clk);
      check_dut(0, "L0", bus0.req_ready, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_data, bus0.in_flight);
      check_dut(1, "L1", bus1.req_ready, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, bus1.in_flight);
      check_dut(2, "L2", bus2.req_ready, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_data, bus2.in_flight);
      @(posedge clk);
      if (w >= 0) begin
         ptr     = (w + 1) % int'(N);
         pend[w] = 1'b0;
      end
      cyc++;
      #1;
      gen_new();
      drive();
   endtask

   task automatic reset_pulse();
      pend = '0;
      drive();
      rstn = 1'b0;
      #1;
      check("L0_rst_valid", 256'(bus0.rsp_valid), 256'(0));
      check("L1_rst_valid", 256'(bus1.rsp_valid), 256'(0));
      check("L2_rst_valid", 256'(bus2.rsp_valid), 256'(0));
      check("L1_rst_in_flight", 256'(bus1.in_flight), 256'(0));
      check("L2_rst_in_flight", 256'(bus2.in_flight), 256'(0));
      clear_hist();
      ptr = 0;
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0;
      pend = '0;
      mode = M_IDLE;
      ptr  = 0;
      cyc  = 8;
      for (int i = 0; i < int'(N); i++) begin
         mx[i] = '0;
         my[i] = '0;
      end
      clear_hist();
      drive();

      // Reset held for 3 cycles, then idle.
      repeat (3) step();
      rstn = 1'b1;
      repeat (10) step();

      // Lone request from requester 2: 5 + 7.
      pend[2] = 1'b1; mx[2] = FP_W'(5); my[2] = FP_W'(7);
      drive();
      repeat (4) step();

      // Every requester continuously valid.
      mode = M_ALL;
      gen_new();
      drive();
      repeat (12) step();

      // Drain, then a wrapping sum.
      mode = M_IDLE;
      repeat (6) step();
      pend[1] = 1'b1; mx[1] = '1; my[1] = FP_W'(2);
      drive();
      repeat (4) step();

      // One requester re-asserting every cycle.
      mode = M_ONE;
      gen_new();
      drive();
      repeat (8) step();

      // Reset while two results are still in the pipe.
      mode = M_ALL;
      gen_new();
      drive();
      repeat (2) step();
      mode = M_IDLE;
      reset_pulse();
      repeat (3) step();

      // Random traffic.
      mode = M_RAND;
      gen_new();
      drive();
      repeat (300) step();

      mode = M_IDLE;
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
